// File: rtl/ldr_pkg.sv
// Shared types and constants for the load (memory-read) controller.
package ldr_pkg;

    localparam int LDR_DATA_W = 16;
    localparam int LDR_ADDR_W = 16;

    localparam logic [15:0] LDR_POISON = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_e;

endpackage

// File: rtl/ldr_addr_gen.sv
// Burst address/beat counter: loads on accept, steps once per non-final handshake.
module ldr_addr_gen #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              advance,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [LEN_W-1:0]  beats_left,
    output logic              last
);

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr   <= '0;
            beats_left <= '0;
        end else if (load) begin
            cur_addr   <= load_addr;
            beats_left <= load_len;
        end else if (advance) begin
            // Address wraps modulo 2^ADDR_W without raising any fault.
            cur_addr   <= cur_addr + ADDR_W'(1);
            beats_left <= beats_left - LEN_W'(1);
        end
    end

    assign last = (beats_left == '0);

endmodule

// File: rtl/ldr_read_ctrl.sv
// Load controller: issues single-cycle reads to a 1-cycle-latency memory and returns words on a valid/ready stream.
// Optional range check enabled by defining LDR_OOB_CHECK_EN.
module ldr_read_ctrl
    import ldr_pkg::*;
#(
    parameter int DATA_W = LDR_DATA_W,
    parameter int ADDR_W = LDR_ADDR_W,
    parameter int DEPTH  = 256,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              err_oob
);

    state_e            state, state_nxt;
    logic              accept, handshake, advance;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  beats_left;
    logic              last;
    logic [DATA_W-1:0] capture_data;

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;
    assign mem_rd_en = (state == ISSUE);
    assign mem_addr  = cur_addr;
    assign rd_valid  = (state == HOLD);
    assign accept    = req_valid && req_ready;
    assign handshake = rd_valid && rd_ready;
    assign advance   = handshake && !rd_last;

    ldr_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_addr  (req_addr),
        .load_len   (req_len),
        .advance    (advance),
        .cur_addr   (cur_addr),
        .beats_left (beats_left),
        .last       (last)
    );

    // NOTE: next-state defaults to the current state first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = ISSUE;
            ISSUE:                  state_nxt = CAPTURE;
            CAPTURE:                state_nxt = HOLD;
            HOLD:    if (handshake) state_nxt = rd_last ? IDLE : ISSUE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            rd_last <= 1'b0;
        end else if (state == CAPTURE) begin
            rd_data <= capture_data;
            rd_last <= last;
        end else if (handshake) begin
            rd_last <= 1'b0;
        end
    end

`ifdef LDR_OOB_CHECK_EN
    logic oob;

    // Out-of-range beats still read memory; only the returned word is poisoned.
    assign oob          = (cur_addr >= ADDR_W'(DEPTH));
    assign capture_data = oob ? DATA_W'(LDR_POISON) : mem_rd_data;

    always_ff @(posedge clk) begin
        if (rst)                           err_oob <= 1'b0;
        else if (accept)                   err_oob <= 1'b0;
        else if (state == CAPTURE && oob)  err_oob <= 1'b1;
    end
`else
    assign capture_data = mem_rd_data;
    assign err_oob      = 1'b0;
`endif

endmodule

// File: tb/tb_ldr_read_ctrl.sv
// Directed bench for ldr_read_ctrl with a preloaded 1-cycle-latency memory model.
module tb_ldr_read_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [3:0]  req_len;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rd_data = 16'h0000;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_last;
    logic        busy;
    logic        err_oob;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef LDR_OOB_CHECK_EN
    localparam logic [15:0] EXP_FFFF = 16'hDEAD;
    localparam logic        EXP_ERR  = 1'b1;
`else
    localparam logic [15:0] EXP_FFFF = 16'hA5A5;
    localparam logic        EXP_ERR  = 1'b0;
`endif

    always #5 clk = ~clk;

    ldr_read_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .rd_last     (rd_last),
        .busy        (busy),
        .err_oob     (err_oob)
    );

    // Preloaded contents; addresses beyond the table return addr ^ 5A5A.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'd0:   return 16'hAAAA;
            16'd1:   return 16'h00AA;
            16'd2:   return 16'h00EE;
            16'd3:   return 16'h00CC;
            16'd4:   return 16'h00BB;
            16'd5:   return 16'h00FF;
            default: return a ^ 16'h5A5A;
        endcase
    endfunction

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_word(mem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Runs one burst with rd_ready high and checks every cycle of the 3-cycle beat.
    task automatic run_burst(input logic [15:0] a, input logic [3:0] l,
                             input logic [0:5][15:0] w, input logic e, input string nm);
        logic [15:0] ea;
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        rd_ready  = 1'b1;
        check({nm, ".req_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        for (int k = 0; k <= int'(l); k++) begin
            ea = a + 16'(k);
            check($sformatf("%s.beat%0d.mem_rd_en", nm, k), 32'(mem_rd_en), 32'd1);
            check($sformatf("%s.beat%0d.mem_addr", nm, k), 32'(mem_addr), 32'(ea));
            check($sformatf("%s.beat%0d.busy", nm, k), 32'(busy), 32'd1);
            if (k == 0) check({nm, ".err_clear"}, 32'(err_oob), 32'd0);
            tick();
            check($sformatf("%s.beat%0d.capture_no_valid", nm, k), 32'(rd_valid), 32'd0);
            tick();
            check($sformatf("%s.beat%0d.rd_valid", nm, k), 32'(rd_valid), 32'd1);
            check($sformatf("%s.beat%0d.rd_data", nm, k), 32'(rd_data), 32'(w[k]));
            check($sformatf("%s.beat%0d.rd_last", nm, k), 32'(rd_last), 32'(k == int'(l)));
            tick();
        end
        check({nm, ".end.req_ready"}, 32'(req_ready), 32'd1);
        check({nm, ".end.rd_valid"}, 32'(rd_valid), 32'd0);
        check({nm, ".end.err_oob"}, 32'(err_oob), 32'(e));
    endtask

    typedef struct {
        string             name;
        logic [15:0]       addr;
        logic [3:0]        len;
        logic [0:5][15:0]  words;
        logic              err;
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{"single",   16'd2,      4'd0, {16'h00EE, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1'b0};
        vecs[1] = '{"burst6",   16'd0,      4'd5, {16'hAAAA, 16'h00AA, 16'h00EE, 16'h00CC, 16'h00BB, 16'h00FF}, 1'b0};
        vecs[2] = '{"burst2",   16'd4,      4'd1, {16'h00BB, 16'h00FF, 16'h0, 16'h0, 16'h0, 16'h0}, 1'b0};
        vecs[3] = '{"wrap",     16'hFFFF,   4'd1, {EXP_FFFF, 16'hAAAA, 16'h0, 16'h0, 16'h0, 16'h0}, EXP_ERR};
        vecs[4] = '{"errclear", 16'd5,      4'd0, {16'h00FF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1'b0};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        rd_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.busy",      32'(busy),      32'd0);
        check("rst.mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst.mem_addr",  32'(mem_addr),  32'd0);
        check("rst.rd_valid",  32'(rd_valid),  32'd0);
        check("rst.rd_data",   32'(rd_data),   32'd0);
        check("rst.rd_last",   32'(rd_last),   32'd0);
        check("rst.err_oob",   32'(err_oob),   32'd0);

        for (int i = 0; i < 5; i++) begin
            run_burst(vecs[i].addr, vecs[i].len, vecs[i].words, vecs[i].err, vecs[i].name);
        end

        // Backpressure: first word must stay stable and no new read until handshake.
        req_valid = 1'b1; req_addr = 16'd1; req_len = 4'd1; rd_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        check("bp.issue0", 32'(mem_addr), 32'd1);
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp.hold%0d.rd_valid", c), 32'(rd_valid), 32'd1);
            check($sformatf("bp.hold%0d.rd_data", c), 32'(rd_data), 32'h00AA);
            check($sformatf("bp.hold%0d.rd_last", c), 32'(rd_last), 32'd0);
            check($sformatf("bp.hold%0d.mem_rd_en", c), 32'(mem_rd_en), 32'd0);
            tick();
        end
        rd_ready = 1'b1;
        tick();
        check("bp.issue1.mem_rd_en", 32'(mem_rd_en), 32'd1);
        check("bp.issue1.mem_addr",  32'(mem_addr),  32'd2);
        tick();
        tick();
        check("bp.word1.rd_data", 32'(rd_data), 32'h00EE);
        check("bp.word1.rd_last", 32'(rd_last), 32'd1);
        tick();
        check("bp.end.req_ready", 32'(req_ready), 32'd1);

        // Request while busy is ignored: only AAAA, 00AA, 00EE come back.
        req_valid = 1'b1; req_addr = 16'd0; req_len = 4'd2;
        tick();
        req_addr = 16'd4; req_len = 4'd0;
        check("busy.req_ready", 32'(req_ready), 32'd0);
        check("busy.busy",      32'(busy),      32'd1);
        tick();
        tick();
        req_valid = 1'b0;
        check("busy.word0", 32'(rd_data), 32'hAAAA);
        tick();
        check("busy.addr1", 32'(mem_addr), 32'd1);
        tick();
        tick();
        check("busy.word1", 32'(rd_data), 32'h00AA);
        tick();
        tick();
        tick();
        check("busy.word2", 32'(rd_data), 32'h00EE);
        check("busy.last2", 32'(rd_last), 32'd1);
        tick();
        for (int c = 0; c < 3; c++) begin
            check($sformatf("busy.after%0d.rd_valid", c), 32'(rd_valid), 32'd0);
            check($sformatf("busy.after%0d.mem_rd_en", c), 32'(mem_rd_en), 32'd0);
            tick();
        end

        // Reset during the second beat discards the rest of the burst.
        req_valid = 1'b1; req_addr = 16'd0; req_len = 4'd5;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("rstmid.word0", 32'(rd_data), 32'hAAAA);
        tick();
        check("rstmid.beat1", 32'(mem_rd_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid.rd_valid",  32'(rd_valid),  32'd0);
        check("rstmid.req_ready", 32'(req_ready), 32'd1);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("rstmid.quiet%0d", c), 32'(rd_valid | mem_rd_en), 32'd0);
            tick();
        end
        run_burst(16'd3, 4'd0, {16'h00CC, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0}, 1'b0, "rstmid.new");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
